// File: rtl/sensor_trace_window.sv
// Trigger-armed capture window for packed sensor lanes: waits a latched delay after
// a trigger rising edge, then emits N_SAMPLES block-averaged samples (2^d per output).
module sensor_trace_window #(
    parameter int LANES          = 8,
    parameter int LANE_W         = 16,
    parameter int N_SAMPLES      = 2048,
    parameter int DELAY_W        = 16,
    parameter int MAX_DECIM_LOG2 = 4,
    parameter int CNT_W          = $clog2(N_SAMPLES) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      trig_i,
    input  logic [DELAY_W-1:0]        delay_i,
    input  logic [2:0]                decim_log2_i,
    input  logic [LANES*LANE_W-1:0]   sensor_i,
    output logic [LANES*LANE_W-1:0]   sample_o,
    output logic                      sample_vld_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [CNT_W-1:0]          sample_cnt_o
);

    localparam int ACC_W = LANE_W + MAX_DECIM_LOG2;
    localparam int PH_W  = (MAX_DECIM_LOG2 > 0) ? MAX_DECIM_LOG2 : 1;
    localparam logic [2:0] MAX_D = 3'(MAX_DECIM_LOG2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DELAY   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      r_trig_q;
    logic [DELAY_W-1:0]        r_delay_cnt;
    logic [2:0]                r_decim;
    logic [PH_W-1:0]           r_phase;
    logic [ACC_W-1:0]          r_acc [LANES];
    logic [LANES*LANE_W-1:0]   r_sample;
    logic                      r_vld;
    logic                      r_busy;
    logic                      r_done;
    logic [CNT_W-1:0]          r_cnt;

    logic                      w_edge;
    logic                      w_start;
    logic                      w_emit;
    logic                      w_phase_last;
    logic [PH_W-1:0]           w_phase_end;
    logic [2:0]                w_decim;
    logic [ACC_W-1:0]          w_sum [LANES];
    logic [ACC_W-1:0]          w_shift [LANES];
    logic [LANES*LANE_W-1:0]   w_avg_word;

    assign w_edge  = trig_i & ~r_trig_q;
    assign w_decim = (decim_log2_i > MAX_D) ? MAX_D : decim_log2_i;

    // Terminal phase of a decimation block is 2^d-1, built as a low-bit mask.
    assign w_phase_end  = ~({PH_W{1'b1}} << r_decim);
    assign w_phase_last = (r_phase == w_phase_end);

    // Per-lane running sum including the current sample, and its truncated average.
    always_comb begin
        w_avg_word = '0;
        for (int k = 0; k < LANES; k++) begin
            w_sum[k]   = r_acc[k] + ACC_W'(sensor_i[k*LANE_W +: LANE_W]);
            w_shift[k] = w_sum[k] >> r_decim;
            w_avg_word[k*LANE_W +: LANE_W] = w_shift[k][LANE_W-1:0];
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_emit      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_edge) begin
                    w_start     = 1'b1;
                    w_state_nxt = (delay_i != '0) ? S_DELAY : S_CAPTURE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DELAY: begin
                if (r_delay_cnt == DELAY_W'(1)) begin
                    w_state_nxt = S_CAPTURE;
                end else begin
                    w_state_nxt = S_DELAY;
                end
            end
            S_CAPTURE: begin
                if (w_phase_last) begin
                    w_emit      = 1'b1;
                    w_state_nxt = (r_cnt == LAST_CNT) ? S_DONE : S_CAPTURE;
                end else begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_DONE: begin
                if (!trig_i) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register, trigger history and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_trig_q <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_vld    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_trig_q <= trig_i;
            r_busy   <= (w_state_nxt == S_DELAY) || (w_state_nxt == S_CAPTURE);
            r_done   <= (w_state_nxt == S_DONE);
            r_vld    <= w_emit;
        end
    end

    // Window configuration latched at the trigger edge; delay counts down in DELAY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_delay_cnt <= '0;
            r_decim     <= 3'd0;
        end else if (w_start) begin
            r_delay_cnt <= delay_i;
            r_decim     <= w_decim;
        end else if (r_state == S_DELAY) begin
            r_delay_cnt <= r_delay_cnt - DELAY_W'(1);
        end else begin
            r_delay_cnt <= r_delay_cnt;
        end
    end

    // Accumulators, phase, output sample and sample counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase  <= '0;
            r_sample <= '0;
            r_cnt    <= '0;
            for (int k = 0; k < LANES; k++) begin
                r_acc[k] <= '0;
            end
        end else if (w_start) begin
            r_phase <= '0;
            r_cnt   <= '0;
            for (int k = 0; k < LANES; k++) begin
                r_acc[k] <= '0;
            end
        end else if (r_state == S_CAPTURE) begin
            if (w_phase_last) begin
                r_phase  <= '0;
                r_sample <= w_avg_word;
                r_cnt    <= r_cnt + CNT_W'(1);
                for (int k = 0; k < LANES; k++) begin
                    r_acc[k] <= '0;
                end
            end else begin
                r_phase <= r_phase + PH_W'(1);
                for (int k = 0; k < LANES; k++) begin
                    r_acc[k] <= w_sum[k];
                end
            end
        end else begin
            r_phase <= r_phase;
        end
    end

    assign sample_o     = r_sample;
    assign sample_vld_o = r_vld;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign sample_cnt_o = r_cnt;

endmodule
